// File: rtl/ring_inject_arbiter_if.sv
// ring_inject_arbiter_if: ring, local-request and downstream-link signals of the injection arbiter.
// The arbiter takes the slave modport; whoever drives the stimulus takes the master modport.
interface ring_inject_arbiter_if #(
    parameter int WIDTH   = 32,
    parameter int NUM_LOC = 4,
    parameter int CREDITS = 2
);
    logic                         iRingVld;
    logic [WIDTH-1:0]             iRingDat;
    logic                         oRingRdy;
    logic [NUM_LOC-1:0]           iReqVld;
    logic [NUM_LOC*WIDTH-1:0]     iReqDat;
    logic [NUM_LOC-1:0]           oReqGnt;
    logic                         oLinkWrEn;
    logic [WIDTH-1:0]             oLinkWrDat;
    logic                         iLinkCredRet;
    logic [$clog2(CREDITS+1)-1:0] oCredCnt;
    logic                         oCredErr;
    logic [15:0]                  oRingGntCnt;
    logic [15:0]                  oLocGntCnt;
    modport master (
        output iRingVld, iRingDat, iReqVld, iReqDat, iLinkCredRet,
        input  oRingRdy, oReqGnt, oLinkWrEn, oLinkWrDat, oCredCnt, oCredErr, oRingGntCnt, oLocGntCnt
    );
    modport slave (
        input  iRingVld, iRingDat, iReqVld, iReqDat, iLinkCredRet,
        output oRingRdy, oReqGnt, oLinkWrEn, oLinkWrDat, oCredCnt, oCredErr, oRingGntCnt, oLocGntCnt
    );
endinterface

// File: rtl/ring_inject_arbiter.sv
// ring_inject_arbiter: shares one credited downstream link between ring traffic and round-robin locals.
// Grant counters exist only when RING_ARB_STATS_EN is defined; otherwise they read 0.
module ring_inject_arbiter #(
    parameter int WIDTH      = 32,
    parameter int NUM_LOC    = 4,
    parameter int CREDITS    = 2,
    parameter int STARVE_LIM = 4
) (
    input logic clk,
    input logic rst,
    ring_inject_arbiter_if.slave bus
);
    localparam int CW = $clog2(CREDITS + 1);
    localparam int PW = $clog2(NUM_LOC);
    localparam int SW = $clog2(STARVE_LIM + 1);
    typedef enum logic {RING_PRI, LOCAL_PRI} state_t;
    state_t           state_q, state_d;
    logic [SW-1:0]    starve_q, starve_d;
    logic [PW-1:0]    ptr_q, ptr_d, sel;
    logic [CW-1:0]    cred_q, cred_d;
    logic [WIDTH-1:0] wr_dat_q, wr_dat_d;
    logic             wr_en_q, err_q, err_d;
    logic             found, ok, loc_first, ring_gnt, loc_gnt, gnt, starve_hit;
    int               j;
    always_comb begin
        found = 1'b0;
        sel   = '0;
        j     = 0;
        for (int k = 0; k < NUM_LOC; k++) begin
            j = int'(ptr_q) + k;
            j = (j >= NUM_LOC) ? j - NUM_LOC : j;
            if (!found && bus.iReqVld[j]) begin
                found = 1'b1;
                sel   = PW'(j);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= RING_PRI;
            starve_q <= '0;
            ptr_q    <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            ptr_q    <= ptr_d;
        end
    end
    always_comb begin
        starve_hit = starve_q == SW'(STARVE_LIM - 1);
        state_d    = (state_q == RING_PRI) ? ((ring_gnt && found && starve_hit) ? LOCAL_PRI : RING_PRI)
                                           : (loc_gnt ? RING_PRI : LOCAL_PRI);
        starve_d   = loc_gnt ? '0
                   : (state_q == RING_PRI && ring_gnt && found) ? (starve_hit ? '0 : starve_q + SW'(1))
                   : starve_q;
        ptr_d      = loc_gnt ? ((sel == PW'(NUM_LOC - 1)) ? '0 : sel + PW'(1)) : ptr_q;
    end
    // Credit is checked on the registered count only, and grants are suppressed during reset.
    always_comb begin
        ok           = rst && (cred_q != '0);
        loc_first    = state_q == LOCAL_PRI;
        ring_gnt     = ok && bus.iRingVld && !(loc_first && found);
        loc_gnt      = ok && found && !(!loc_first && bus.iRingVld);
        gnt          = ring_gnt || loc_gnt;
        bus.oRingRdy = ring_gnt;
        bus.oReqGnt  = loc_gnt ? (NUM_LOC'(1) << sel) : '0;
    end
    always_comb begin
        cred_d   = (gnt && !bus.iLinkCredRet) ? cred_q - CW'(1)
                 : (!gnt && bus.iLinkCredRet && cred_q != CW'(CREDITS)) ? cred_q + CW'(1)
                 : cred_q;
        err_d    = err_q || (bus.iLinkCredRet && !gnt && cred_q == CW'(CREDITS));
        wr_dat_d = ring_gnt ? bus.iRingDat : loc_gnt ? bus.iReqDat[sel*WIDTH +: WIDTH] : wr_dat_q;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_en_q  <= 1'b0;
            wr_dat_q <= '0;
            cred_q   <= CW'(CREDITS);
            err_q    <= 1'b0;
        end else begin
            wr_en_q  <= gnt;
            wr_dat_q <= wr_dat_d;
            cred_q   <= cred_d;
            err_q    <= err_d;
        end
    end
    assign bus.oLinkWrEn  = wr_en_q;
    assign bus.oLinkWrDat = wr_dat_q;
    assign bus.oCredCnt   = cred_q;
    assign bus.oCredErr   = err_q;
`ifdef RING_ARB_STATS_EN
    logic [15:0] ring_cnt_q, loc_cnt_q;
    always_ff @(posedge clk) begin
        if (!rst) begin
            ring_cnt_q <= '0;
            loc_cnt_q  <= '0;
        end else begin
            ring_cnt_q <= ring_cnt_q + 16'(ring_gnt);
            loc_cnt_q  <= loc_cnt_q + 16'(loc_gnt);
        end
    end
    assign bus.oRingGntCnt = ring_cnt_q;
    assign bus.oLocGntCnt  = loc_cnt_q;
`else
    assign bus.oRingGntCnt = '0;
    assign bus.oLocGntCnt  = '0;
`endif
endmodule

// File: tb/tb_ring_inject_arbiter.sv
// tb_ring_inject_arbiter: directed checks of priority, starvation, round-robin, credits and reset.
module tb_ring_inject_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    ring_inject_arbiter_if #(.WIDTH(32), .NUM_LOC(4), .CREDITS(2)) bus ();
    ring_inject_arbiter #(.WIDTH(32), .NUM_LOC(4), .CREDITS(2), .STARVE_LIM(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    // Drive one cycle's inputs, check the combinational grants, then clock it.
    task automatic cyc(input string tag, input logic rv, input logic [31:0] rd, input logic [3:0] qv,
                       input logic ret, input logic exp_rdy, input logic [3:0] exp_gnt);
        bus.iRingVld     = rv;
        bus.iRingDat     = rd;
        bus.iReqVld      = qv;
        bus.iLinkCredRet = ret;
        #1;
        chk({tag, ".rdy"}, 64'(bus.oRingRdy), 64'(exp_rdy));
        chk({tag, ".gnt"}, 64'(bus.oReqGnt), 64'(exp_gnt));
        tick();
    endtask
    task automatic chk_wr(input string tag, input logic en, input logic [31:0] dat, input logic [1:0] cred);
        chk({tag, ".wren"}, 64'(bus.oLinkWrEn), 64'(en));
        chk({tag, ".wrdat"}, 64'(bus.oLinkWrDat), 64'(dat));
        chk({tag, ".cred"}, 64'(bus.oCredCnt), 64'(cred));
    endtask
    initial begin
        logic [3:0]  gnt_seq [5];
        logic [31:0] dat_seq [5];
        gnt_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        dat_seq = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h100};
        bus.iReqDat = {32'h103, 32'h102, 32'h101, 32'h100};
        rst = 1'b0;
        cyc("rst", 1'b1, 32'h55, 4'hf, 1'b0, 1'b0, 4'h0);
        tick();
        chk_wr("rst", 1'b0, 32'h0, 2'd2);
        chk("rst.err", 64'(bus.oCredErr), 64'd0);
        rst = 1'b1;
        cyc("idle", 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 4'h0);
        chk_wr("idle", 1'b0, 32'h0, 2'd2);
        cyc("ring0", 1'b1, 32'hA0, 4'h0, 1'b0, 1'b1, 4'h0);
        chk_wr("ring0", 1'b1, 32'hA0, 2'd1);
        for (int k = 1; k < 4; k++) begin
            cyc("ring", 1'b1, 32'hA0 + 32'(k), 4'h0, 1'b1, 1'b1, 4'h0);
            chk_wr("ring", 1'b1, 32'hA0 + 32'(k), 2'd1);
        end
        cyc("ringend", 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 4'h0);
        chk_wr("ringend", 1'b0, 32'hA3, 2'd2);
        for (int k = 0; k < 4; k++) begin
            cyc("starve", 1'b1, 32'hB0 + 32'(k), 4'b0001, 1'b1, 1'b1, 4'h0);
            chk_wr("starve", 1'b1, 32'hB0 + 32'(k), 2'd2);
        end
        cyc("forced", 1'b1, 32'hB4, 4'b0001, 1'b1, 1'b0, 4'b0001);
        chk_wr("forced", 1'b1, 32'h100, 2'd2);
        cyc("ringback", 1'b1, 32'hB5, 4'b0001, 1'b1, 1'b1, 4'h0);
        chk_wr("ringback", 1'b1, 32'hB5, 2'd2);
        rst = 1'b0;
        cyc("midrst", 1'b1, 32'hB6, 4'b0001, 1'b1, 1'b0, 4'h0);
        chk_wr("midrst", 1'b0, 32'h0, 2'd2);
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc("rr", 1'b0, 32'h0, 4'hf, 1'b1, 1'b0, gnt_seq[k]);
            chk_wr("rr", 1'b1, dat_seq[k], 2'd2);
        end
        cyc("cred0", 1'b1, 32'hC0, 4'h0, 1'b0, 1'b1, 4'h0);
        chk_wr("cred0", 1'b1, 32'hC0, 2'd1);
        cyc("cred1", 1'b1, 32'hC1, 4'h0, 1'b0, 1'b1, 4'h0);
        chk_wr("cred1", 1'b1, 32'hC1, 2'd0);
        cyc("cred2", 1'b1, 32'hC2, 4'h0, 1'b0, 1'b0, 4'h0);
        chk_wr("cred2", 1'b0, 32'hC1, 2'd0);
        cyc("cred3", 1'b1, 32'hC3, 4'h0, 1'b1, 1'b0, 4'h0);
        chk_wr("cred3", 1'b0, 32'hC1, 2'd1);
        cyc("cred4", 1'b1, 32'hC4, 4'h0, 1'b0, 1'b1, 4'h0);
        chk_wr("cred4", 1'b1, 32'hC4, 2'd0);
        cyc("cred5", 1'b1, 32'hC5, 4'h0, 1'b0, 1'b0, 4'h0);
        chk_wr("cred5", 1'b0, 32'hC4, 2'd0);
        cyc("ret0", 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 4'h0);
        cyc("ret1", 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 4'h0);
        chk("ret1.cred", 64'(bus.oCredCnt), 64'd2);
        chk("ret1.err", 64'(bus.oCredErr), 64'd0);
        cyc("over", 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 4'h0);
        chk("over.cred", 64'(bus.oCredCnt), 64'd2);
        chk("over.err", 64'(bus.oCredErr), 64'd1);
        cyc("sticky", 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 4'h0);
        chk("sticky.err", 64'(bus.oCredErr), 64'd1);
        rst = 1'b0;
        cyc("errrst", 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 4'h0);
        chk("errrst.err", 64'(bus.oCredErr), 64'd0);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc("string", 1'b1, 32'hD0 + 32'(k), 4'h0, 1'b1, 1'b1, 4'h0);
            chk_wr("string", 1'b1, 32'hD0 + 32'(k), 2'd2);
        end
        cyc("stloc0", 1'b0, 32'h0, 4'b0011, 1'b1, 1'b0, 4'b0001);
        chk_wr("stloc0", 1'b1, 32'h100, 2'd2);
        cyc("stloc1", 1'b0, 32'h0, 4'b0011, 1'b1, 1'b0, 4'b0010);
        chk_wr("stloc1", 1'b1, 32'h101, 2'd2);
`ifdef RING_ARB_STATS_EN
        chk("stats.ring", 64'(bus.oRingGntCnt), 64'd3);
        chk("stats.loc", 64'(bus.oLocGntCnt), 64'd2);
`else
        chk("stats.ring", 64'(bus.oRingGntCnt), 64'd0);
        chk("stats.loc", 64'(bus.oLocGntCnt), 64'd0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
